// File: rtl/tcdb_arbiter_if.sv
// Bundle between the result producers, the CDB arbiter and the reservation-station consumers.
// Latency: none (wires only).
// Backpressure: per-producer valid/ready on src_*; bcast_* has no ready and is consumed when valid.
interface tcdb_arbiter_if #(
    parameter int tag_width  = 8,
    parameter int data_width = 128,
    parameter int num_src    = 4
);
    localparam int src_w = $clog2(num_src);

    logic [num_src-1:0]            src_valid;
    logic [num_src-1:0]            src_ready;
    logic [num_src*tag_width-1:0]  src_tag;
    logic [num_src*data_width-1:0] src_data;
    logic                          bcast_stall;
    logic                          bcast_valid;
    logic [tag_width-1:0]          bcast_tag;
    logic [data_width-1:0]         bcast_data;
    logic [src_w-1:0]              bcast_src;
    logic [15:0]                   bcast_count;

    // Producer/consumer side: drives results and stall, observes ready and the broadcast.
    modport master (
        output src_valid, src_tag, src_data, bcast_stall,
        input  src_ready, bcast_valid, bcast_tag, bcast_data, bcast_src, bcast_count
    );

    // Arbiter side.
    modport slave (
        input  src_valid, src_tag, src_data, bcast_stall,
        output src_ready, bcast_valid, bcast_tag, bcast_data, bcast_src, bcast_count
    );
endinterface

// File: rtl/tcdb_arbiter.sv
// Common-data-bus arbiter: per-producer FIFOs, round-robin pick, registered result broadcast.
// Latency: result accepted at edge E0 is broadcast after edge E1 (two cycles handshake-to-valid).
// Backpressure: src_ready[i] drops only when FIFO i is full (registered count); bcast_stall blocks grants.
module tcdb_arbiter #(
    parameter int tag_width  = 8,
    parameter int data_width = 128,
    parameter int num_src    = 4,
    parameter int fifo_depth = 2
) (
    input  logic          clk,
    input  logic          rst,
    tcdb_arbiter_if.slave bus
);
    localparam int src_w = $clog2(num_src);
    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = ptr_w + 1;

    logic [tag_width-1:0]  tag_mem  [num_src][fifo_depth];
    logic [data_width-1:0] data_mem [num_src][fifo_depth];

    logic [num_src-1:0][ptr_w-1:0] rd_ptr;
    logic [num_src-1:0][ptr_w-1:0] wr_ptr;
    logic [num_src-1:0][cnt_w-1:0] cnt;

    logic [num_src-1:0] ready;
    logic [num_src-1:0] not_empty;
    logic [num_src-1:0] push;
    logic [num_src-1:0] pop;

    logic [src_w-1:0] rr_ptr;
    logic [src_w-1:0] winner;
    logic             grant;

    logic                  bcast_valid_q;
    logic [tag_width-1:0]  bcast_tag_q;
    logic [data_width-1:0] bcast_data_q;
    logic [src_w-1:0]      bcast_src_q;
    logic [15:0]           bcast_count_q;

    // Ready/occupancy come from registered counts only, so a same-cycle pop never raises ready.
    always_comb begin
        ready     = '0;
        not_empty = '0;
        push      = '0;
        for (int i = 0; i < num_src; i++) begin
            ready[i]     = (cnt[i] < cnt_w'(fifo_depth));
            not_empty[i] = (cnt[i] != '0);
            push[i]      = bus.src_valid[i] & ready[i];
        end
    end

    // Round-robin scan from rr_ptr; scanning offsets high-to-low lets the lowest offset win.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = 1'b0;
        winner = '0;
        pop    = '0;
        if (!bus.bcast_stall) begin
            for (int k = num_src - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr) + k) % num_src;
                if (not_empty[idx]) begin
                    grant  = 1'b1;
                    winner = src_w'(idx);
                end
            end
        end
        for (int i = 0; i < num_src; i++) begin
            pop[i] = grant && (winner == src_w'(i));
        end
    end

    // FIFO storage; contents are only observable through counted entries, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < num_src; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]  <= bus.src_tag[i*tag_width +: tag_width];
                data_mem[i][wr_ptr[i]] <= bus.src_data[i*data_width +: data_width];
            end
        end
    end

    // FIFO pointers/counts, round-robin pointer and the registered broadcast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            cnt           <= '0;
            rr_ptr        <= '0;
            bcast_valid_q <= 1'b0;
            bcast_tag_q   <= '0;
            bcast_data_q  <= '0;
            bcast_src_q   <= '0;
            bcast_count_q <= '0;
        end else begin
            for (int i = 0; i < num_src; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + ptr_w'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + ptr_w'(1);
                cnt[i] <= cnt[i] + cnt_w'(push[i]) - cnt_w'(pop[i]);
            end
            if (grant) begin
                bcast_valid_q <= 1'b1;
                bcast_tag_q   <= tag_mem[winner][rd_ptr[winner]];
                bcast_data_q  <= data_mem[winner][rd_ptr[winner]];
                bcast_src_q   <= winner;
                bcast_count_q <= bcast_count_q + 16'd1;
                rr_ptr        <= (winner == src_w'(num_src - 1)) ? '0 : winner + src_w'(1);
            end else begin
                // Tag/data/src hold; consumers qualify with valid.
                bcast_valid_q <= 1'b0;
            end
        end
    end

    assign bus.src_ready   = ready;
    assign bus.bcast_valid = bcast_valid_q;
    assign bus.bcast_tag   = bcast_tag_q;
    assign bus.bcast_data  = bcast_data_q;
    assign bus.bcast_src   = bcast_src_q;
    assign bus.bcast_count = bcast_count_q;
endmodule

// File: tb/tb_tcdb_arbiter.sv
// Directed bench for tcdb_arbiter: reset, single result, round-robin, full FIFO, streaming, counter wrap.
// Latency: outputs sampled 1ns after each rising edge; inputs driven at the same point.
// Backpressure: exercised via bcast_stall and a held producer on a full FIFO.
module tb_tcdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   drops  = 0;

    tcdb_arbiter_if bus ();

    tcdb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [7:0] t, input logic [127:0] d);
        bus.src_valid[i]         = v;
        bus.src_tag[i*8 +: 8]    = t;
        bus.src_data[i*128 +: 128] = d;
    endtask

    task automatic chk_bcast(input string tg, input logic [7:0] t, input logic [1:0] s, input logic [127:0] d);
        chk({tg, "_valid"}, 128'(bus.bcast_valid), 128'd1);
        chk({tg, "_tag"},   128'(bus.bcast_tag),   128'(t));
        chk({tg, "_src"},   128'(bus.bcast_src),   128'(s));
        chk({tg, "_data"},  128'(bus.bcast_data),  d);
    endtask

    initial begin
        rst             = 1'b1;
        bus.src_valid   = '0;
        bus.src_tag     = '0;
        bus.src_data    = '0;
        bus.bcast_stall = 1'b0;
        step();
        step();
        chk("rst_valid", 128'(bus.bcast_valid), 128'd0);
        chk("rst_count", 128'(bus.bcast_count), 128'd0);
        chk("rst_ready", 128'(bus.src_ready),   128'hF);
        rst = 1'b0;

        // Single result on producer 2.
        set_src(2, 1'b1, 8'h2A, 128'h1234);
        step();
        chk("single_e0_valid", 128'(bus.bcast_valid), 128'd0);
        set_src(2, 1'b0, 8'h00, 128'h0);
        step();
        chk_bcast("single_e1", 8'h2A, 2'd2, 128'h1234);
        chk("single_e1_count", 128'(bus.bcast_count), 128'd1);
        step();
        chk("single_e2_valid", 128'(bus.bcast_valid), 128'd0);
        chk("single_e2_tag_hold", 128'(bus.bcast_tag), 128'h2A);
        chk("single_e2_count", 128'(bus.bcast_count), 128'd1);

        // Buffer three results under stall, then reset mid-cycle.
        bus.bcast_stall = 1'b1;
        set_src(0, 1'b1, 8'h70, 128'h70);
        set_src(1, 1'b1, 8'h71, 128'h71);
        set_src(3, 1'b1, 8'h73, 128'h73);
        step();
        bus.src_valid = '0;
        chk("stall_valid", 128'(bus.bcast_valid), 128'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 128'(bus.bcast_valid), 128'd0);
        chk("midrst_tag",   128'(bus.bcast_tag),   128'd0);
        chk("midrst_data",  bus.bcast_data,        128'd0);
        chk("midrst_src",   128'(bus.bcast_src),   128'd0);
        chk("midrst_count", 128'(bus.bcast_count), 128'd0);
        #1;
        rst             = 1'b0;
        bus.bcast_stall = 1'b0;
        chk("postrst_ready", 128'(bus.src_ready), 128'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("postrst_no_stale", 128'(bus.bcast_valid), 128'd0);
        end

        // Round-robin: all four push together, ptr starts at 0.
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 8'(i), 128'(i + 100));
        step();
        bus.src_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_bcast("rr", 8'(i), 2'(i), 128'(i + 100));
        end
        chk("rr_count", 128'(bus.bcast_count), 128'd4);
        step();
        chk("rr_idle_valid", 128'(bus.bcast_valid), 128'd0);
        set_src(0, 1'b1, 8'h50, 128'h50);
        set_src(3, 1'b1, 8'h53, 128'h53);
        step();
        bus.src_valid = '0;
        step();
        chk_bcast("rr2_first", 8'h50, 2'd0, 128'h50);
        step();
        chk_bcast("rr2_second", 8'h53, 2'd3, 128'h53);
        chk("rr2_count", 128'(bus.bcast_count), 128'd6);
        step();
        chk("rr2_idle", 128'(bus.bcast_valid), 128'd0);

        // Full FIFO under stall on producer 1.
        bus.bcast_stall = 1'b1;
        set_src(1, 1'b1, 8'hA0, 128'hA0);
        step();
        chk("full_ready_after1", 128'(bus.src_ready[1]), 128'd1);
        set_src(1, 1'b1, 8'hB0, 128'hB0);
        step();
        chk("full_ready_after2", 128'(bus.src_ready[1]), 128'd0);
        set_src(1, 1'b1, 8'hC0, 128'hC0);
        step();
        chk("full_held_ready", 128'(bus.src_ready[1]), 128'd0);
        chk("full_stall_valid", 128'(bus.bcast_valid), 128'd0);
        bus.bcast_stall = 1'b0;
        step();
        chk_bcast("full_a", 8'hA0, 2'd1, 128'hA0);
        chk("full_ready_reopen", 128'(bus.src_ready[1]), 128'd1);
        step();
        bus.src_valid = '0;
        chk_bcast("full_b", 8'hB0, 2'd1, 128'hB0);
        step();
        chk_bcast("full_c", 8'hC0, 2'd1, 128'hC0);
        step();
        chk("full_no_dup", 128'(bus.bcast_valid), 128'd0);
        chk("full_count", 128'(bus.bcast_count), 128'd9);

        // Streaming after a clean reset.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_src(0, 1'b1, 8'(8'h10 + k), 128'(k));
            step();
            chk("stream_ready", 128'(bus.src_ready[0]), 128'd1);
            if (k > 0) chk_bcast("stream", 8'(8'h10 + k - 1), 2'd0, 128'(k - 1));
        end
        bus.src_valid = '0;
        step();
        chk_bcast("stream_last", 8'h23, 2'd0, 128'd19);
        chk("stream_count", 128'(bus.bcast_count), 128'd20);
        step();
        chk("stream_idle", 128'(bus.bcast_valid), 128'd0);

        // Counter wrap: 65515 more broadcasts to reach 16'hFFFF, then one more.
        for (int n = 0; n < 65515; n++) begin
            set_src(0, 1'b1, n[7:0], 128'(n));
            step();
            if (!bus.src_ready[0]) drops++;
        end
        bus.src_valid = '0;
        chk("wrap_ready_drops", 128'(drops), 128'd0);
        step();
        chk("wrap_last_valid", 128'(bus.bcast_valid), 128'd1);
        step();
        chk("wrap_ffff", 128'(bus.bcast_count), 128'hFFFF);
        set_src(0, 1'b1, 8'hEE, 128'hEE);
        step();
        bus.src_valid = '0;
        step();
        chk_bcast("wrap_grant", 8'hEE, 2'd0, 128'hEE);
        chk("wrap_zero", 128'(bus.bcast_count), 128'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tcdb_arbiter.md
# tcdb_arbiter

Common-data-bus arbiter that sits directly downstream of the functional units and upstream of the four-entry reservation stations. It accepts completed results (writeback tag + data) from `num_src` producers over valid/ready handshakes and buffers each producer's results in a small FIFO. Once per cycle it selects one buffered result by round-robin and drives it as a registered broadcast: `bcast_valid`, `bcast_tag` and `bcast_data`. The reservation stations use this broadcast to wake waiting operands.

## Interface
- `tag_width`, 8, writeback tag width; matches reservation-station tags.
- `data_width`, 128, result data width.
- `num_src`, 4, number of producers; 2..8.
- `fifo_depth`, 2, entries per producer FIFO; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `src_valid`  in  num_src  producer i has a result (bit i).
- `src_ready`  out  num_src  FIFO i can accept.
- `src_tag`  in  num_src*tag_width  producer i tag in bits [i*tag_width +: tag_width].
- `src_data`  in  num_src*data_width  producer i data in bits [i*data_width +: data_width].
- `bcast_stall`  in  1  suppress new grants this cycle.
- `bcast_valid`  out  1  broadcast present this cycle.
- `bcast_tag`  out  tag_width  broadcast tag.
- `bcast_data`  out  data_width  broadcast data.
- `bcast_src`  out  clog2(num_src)  index of granted producer.
- `bcast_count`  out  16  total broadcasts issued, wraps at 65535→0.

## Operation
- **Per-producer FIFO.** Each producer has a circular FIFO with a read pointer, a write pointer and an occupancy count of width clog2(fifo_depth)+1.
  - `src_ready[i]` = (count_i < fifo_depth). It depends only on registered count; a same-cycle pop does not raise ready.
  - A push occurs when `src_valid[i] & src_ready[i]` at the edge.
  - Per-producer order is strictly preserved.
- **Arbitration.** Each cycle in which `bcast_stall`=0 and at least one FIFO is non-empty, one FIFO is granted.
  - The winner is the first non-empty index scanning ptr, ptr+1, …, wrapping modulo num_src.
  - On the edge the winner is popped and its head is registered onto `bcast_tag`/`bcast_data`/`bcast_src`, with `bcast_valid`=1.
  - ptr ← (winner+1) mod num_src. ptr is unchanged when there is no grant.
- **No grant.** With no grant (all FIFOs empty, or stall=1), the next edge sets `bcast_valid`=0.
  - `bcast_tag`/`bcast_data`/`bcast_src` hold their last values.
  - Consumers qualify everything by `bcast_valid`.
- **No downstream backpressure.** A broadcast is consumed in the cycle it is valid.
- **Counter.** `bcast_count` increments by 1 on every edge that registers a grant.
- **Push and pop together.** Simultaneous push and pop on the same FIFO leaves count unchanged; both pointers advance.

## Timing
- **Reset.** `rst`=1 asynchronously forces all of the following, at any time, including mid-operation; in-flight buffered results are discarded.
  - All FIFO counts and pointers → 0.
  - ptr → 0.
  - `bcast_valid`, `bcast_tag`, `bcast_data`, `bcast_src`, `bcast_count` → 0.
  - `src_ready` → all ones, since it follows count.
- **Latency.** A result accepted at edge E0 is eligible for arbitration in the cycle after E0. With no contention it appears on `bcast_*` after edge E1, so `bcast_valid` is high in the second cycle after the handshake cycle.
- **Throughput.** One broadcast per cycle sustained.
  - A single producer pushing every cycle into a FIFO with depth ≥2 never sees `src_ready` drop, because pop and push overlap.
- **Full FIFO.** `src_ready[i]`=0; `src_valid[i]` is ignored; the producer must hold its data.
- **Stall.** `bcast_stall` is sampled at the edge. While it is held high, FIFOs only fill, so ready drops once a FIFO is full.
- **Fairness.** Worst-case wait for a non-empty FIFO is num_src−1 grants.

## Test plan
- **Reset.** Assert `rst` mid-cycle with 3 entries buffered. Required: all outputs 0 immediately; after release, `src_ready`=4'b1111; no stale broadcast ever appears.
- **Single result.** Push tag 8'h2A / data 128'h1234 on producer 2 at edge E0. Required: `bcast_valid`=1, `bcast_tag`=8'h2A, `bcast_src`=2 after E1; `bcast_valid`=0 after E2; `bcast_count`=1.
- **Round-robin.** All four producers push simultaneously, each with tag = index. Required: broadcasts in order tags 0,1,2,3 on consecutive cycles; then a new push on producers 0 and 3 is granted 0 then 3.
- **Full/backpressure.** Assert `bcast_stall`=1 while producer 1 pushes 3 results. Required: `src_ready[1]`=0 after 2 accepts and the third is held. Release stall: required output order is tags A, B, then C, with no loss or duplication.
- **Streaming.** Producer 0 pushes every cycle for 20 cycles. Required: `src_ready[0]` stays 1; 20 consecutive valid broadcasts in order; `bcast_count`=20.
- **Counter wrap.** Preload activity so `bcast_count`=16'hFFFF, then issue one grant. Required: `bcast_count`=16'h0000.
